// File: rtl/intersection_pkg.sv
// Shared definitions for the intersection sequencer and the light decoder.
//   phase_e : 3-bit light phase code driven on fsmOut
//   TIMER_W : width of the whole-seconds phase timer (timeLeft)
package intersection_pkg;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned TIMER_W = 8;

  // Phase codes; the enum members double as the named codes the decoder uses.
  typedef enum logic [PHASE_W-1:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    PED_A     = 3'd2,
    EW_LEFT   = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    PED_B     = 3'd6,
    NS_LEFT   = 3'd7
  } phase_e;

endpackage

// File: rtl/tick_prescaler.sv
// One-second tick generator.
//   clock, resetn : clock and asynchronous active-low reset
//   run           : count enable; counter holds while 0
//   clear         : restart the count at 0 on the next edge
//   tick          : high on the cycle the count equals CLK_PER_SEC-1 while running
module tick_prescaler #(
  parameter int unsigned CLK_PER_SEC = 50_000_000
) (
  input  logic clock,
  input  logic resetn,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick is only meaningful while running, so it gates on run.
  assign tick = run && (cnt_q == LAST);

  // Count with wrap; clear restarts the second at a phase boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/intersection_sequencer.sv
// Four-way intersection phase sequencer.
//   clock, resetn               : clock and asynchronous active-low reset
//   run                         : 0 freezes the prescaler and phase timer
//   pedReq, nsLeftReq, ewLeftReq: request inputs, latched until served
//   fsmOut                      : current phase code (registered)
//   timeLeft                    : whole seconds remaining in phase minus 1 (registered)
//   pedPending, nsLeftPending, ewLeftPending : request latch states (registered)
module intersection_sequencer
  import intersection_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 50_000_000,
  parameter int unsigned T_GREEN     = 20,
  parameter int unsigned T_YELLOW    = 3,
  parameter int unsigned T_PED       = 10,
  parameter int unsigned T_LEFT      = 6
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               run,
  input  logic               pedReq,
  input  logic               nsLeftReq,
  input  logic               ewLeftReq,
  output logic [PHASE_W-1:0] fsmOut,
  output logic [TIMER_W-1:0] timeLeft,
  output logic               pedPending,
  output logic               nsLeftPending,
  output logic               ewLeftPending
);

  localparam logic [TIMER_W-1:0] LD_GREEN  = TIMER_W'(T_GREEN - 1);
  localparam logic [TIMER_W-1:0] LD_YELLOW = TIMER_W'(T_YELLOW - 1);
  localparam logic [TIMER_W-1:0] LD_PED    = TIMER_W'(T_PED - 1);
  localparam logic [TIMER_W-1:0] LD_LEFT   = TIMER_W'(T_LEFT - 1);

  phase_e             state_q, state_d, next_phase_c;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               ped_q, ped_d;
  logic               ns_left_q, ns_left_d;
  logic               ew_left_q, ew_left_d;
  logic               tick_c;
  logic               expire_c;

  // Timer reload value (duration minus 1) for a phase.
  function automatic logic [TIMER_W-1:0] phase_load(input phase_e p);
    logic [TIMER_W-1:0] ld;
    case (p)
      NS_GREEN, EW_GREEN:   ld = LD_GREEN;
      NS_YELLOW, EW_YELLOW: ld = LD_YELLOW;
      PED_A, PED_B:         ld = LD_PED;
      default:              ld = LD_LEFT;
    endcase
    return ld;
  endfunction

  tick_prescaler #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_prescaler (
    .clock (clock),
    .resetn(resetn),
    .run   (run),
    .clear (expire_c),
    .tick  (tick_c)
  );

  assign expire_c = tick_c && (timer_q == '0);

  // Successor phase; optional phases are inserted from the registered latches.
  always_comb begin
    next_phase_c = state_q;
    case (state_q)
      NS_GREEN:  next_phase_c = NS_YELLOW;
      NS_YELLOW: next_phase_c = ped_q ? PED_A : (ew_left_q ? EW_LEFT : EW_GREEN);
      PED_A:     next_phase_c = ew_left_q ? EW_LEFT : EW_GREEN;
      EW_LEFT:   next_phase_c = EW_GREEN;
      EW_GREEN:  next_phase_c = EW_YELLOW;
      EW_YELLOW: next_phase_c = ped_q ? PED_B : (ns_left_q ? NS_LEFT : NS_GREEN);
      PED_B:     next_phase_c = ns_left_q ? NS_LEFT : NS_GREEN;
      NS_LEFT:   next_phase_c = NS_GREEN;
      default:   next_phase_c = NS_GREEN;
    endcase
  end

  // Phase state and timer update on each one-second tick.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (expire_c) begin
      state_d = next_phase_c;
      timer_d = phase_load(next_phase_c);
    end else if (tick_c) begin
      timer_d = timer_q - TIMER_W'(1);
    end
  end

  // Request latches: set on request, cleared (with priority) while being served.
  always_comb begin
    ped_d     = (ped_q | pedReq) & ~((state_q == PED_A) || (state_q == PED_B));
    ew_left_d = (ew_left_q | ewLeftReq) & ~(state_q == EW_LEFT);
    ns_left_d = (ns_left_q | nsLeftReq) & ~(state_q == NS_LEFT);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= NS_GREEN;
      timer_q   <= LD_GREEN;
      ped_q     <= 1'b0;
      ns_left_q <= 1'b0;
      ew_left_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ped_q     <= ped_d;
      ns_left_q <= ns_left_d;
      ew_left_q <= ew_left_d;
    end
  end

  assign fsmOut        = state_q;
  assign timeLeft      = timer_q;
  assign pedPending    = ped_q;
  assign nsLeftPending = ns_left_q;
  assign ewLeftPending = ew_left_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Directed self-checking bench for intersection_sequencer (CLK_PER_SEC=4,
// T_GREEN=3, T_YELLOW=2, T_PED=2, T_LEFT=1). Cycle index cyc counts clock
// edges since reset release; outputs are sampled on the falling edge.
module tb_intersection_sequencer;

  logic       clock = 1'b0;
  logic       resetn;
  logic       run;
  logic       pedReq;
  logic       nsLeftReq;
  logic       ewLeftReq;
  logic [2:0] fsmOut;
  logic [7:0] timeLeft;
  logic       pedPending;
  logic       nsLeftPending;
  logic       ewLeftPending;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  intersection_sequencer #(
    .CLK_PER_SEC(4),
    .T_GREEN    (3),
    .T_YELLOW   (2),
    .T_PED      (2),
    .T_LEFT     (1)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .run          (run),
    .pedReq       (pedReq),
    .nsLeftReq    (nsLeftReq),
    .ewLeftReq    (ewLeftReq),
    .fsmOut       (fsmOut),
    .timeLeft     (timeLeft),
    .pedPending   (pedPending),
    .nsLeftPending(nsLeftPending),
    .ewLeftPending(ewLeftPending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Advance to falling edge number n after reset release.
  task automatic step_to(input int n);
    while (cyc < n) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    cyc = 0;
  endtask

  task automatic chk_phase(input string tag, input int unsigned code);
    chk(tag, 32'(fsmOut), 32'(code));
  endtask

  initial begin
    run = 1'b1; pedReq = 1'b0; nsLeftReq = 1'b0; ewLeftReq = 1'b0;
    resetn = 1'b0;
    @(negedge clock);

    // Reset values while held in reset.
    chk_phase("rst_fsm", 0);
    chk("rst_tl", 32'(timeLeft), 2);
    chk("rst_ped", 32'(pedPending), 0);
    chk("rst_nsl", 32'(nsLeftPending), 0);
    chk("rst_ewl", 32'(ewLeftPending), 0);

    // Scenario 1: no requests, 0(12) -> 1(8) -> 4(12) -> 5(8) -> 0.
    do_reset();
    chk_phase("s1_c0", 0);
    chk("s1_tl0", 32'(timeLeft), 2);
    step_to(4);  chk("s1_tl4", 32'(timeLeft), 1);
    step_to(8);  chk("s1_tl8", 32'(timeLeft), 0);
    step_to(11); chk_phase("s1_c11", 0);
    step_to(12); chk_phase("s1_c12", 1); chk("s1_tl12", 32'(timeLeft), 1);
    step_to(19); chk_phase("s1_c19", 1);
    step_to(20); chk_phase("s1_c20", 4); chk("s1_tl20", 32'(timeLeft), 2);
    step_to(31); chk_phase("s1_c31", 4);
    step_to(32); chk_phase("s1_c32", 5);
    step_to(39); chk_phase("s1_c39", 5);
    step_to(40); chk_phase("s1_c40", 0); chk("s1_tl40", 32'(timeLeft), 2);

    // Scenario 2: one-cycle pedestrian pulse during NS_GREEN.
    do_reset();
    step_to(2);  pedReq = 1'b1;
    step_to(3);  pedReq = 1'b0; chk("s2_pend3", 32'(pedPending), 1);
    step_to(19); chk_phase("s2_c19", 1); chk("s2_pend19", 32'(pedPending), 1);
    step_to(20); chk_phase("s2_c20", 2);
    step_to(21); chk("s2_pend21", 32'(pedPending), 0);
    step_to(27); chk_phase("s2_c27", 2);
    step_to(28); chk_phase("s2_c28", 4);
    step_to(47); chk_phase("s2_c47", 5);
    step_to(48); chk_phase("s2_c48", 0);

    // Scenario 3: EW left during NS_GREEN, NS left during EW_GREEN.
    do_reset();
    step_to(2);  ewLeftReq = 1'b1;
    step_to(3);  ewLeftReq = 1'b0; chk("s3_ewl3", 32'(ewLeftPending), 1);
    step_to(20); chk_phase("s3_c20", 3); chk("s3_tl20", 32'(timeLeft), 0);
    step_to(23); chk_phase("s3_c23", 3);
    step_to(24); chk_phase("s3_c24", 4);
    step_to(25); chk("s3_ewl25", 32'(ewLeftPending), 0);
    step_to(26); nsLeftReq = 1'b1;
    step_to(27); nsLeftReq = 1'b0; chk("s3_nsl27", 32'(nsLeftPending), 1);
    step_to(36); chk_phase("s3_c36", 5);
    step_to(44); chk_phase("s3_c44", 7);
    step_to(47); chk_phase("s3_c47", 7);
    step_to(48); chk_phase("s3_c48", 0);
    step_to(49); chk("s3_nsl49", 32'(nsLeftPending), 0);

    // Scenario 4: pedestrian request held high; both PED phases every round.
    pedReq = 1'b1;
    do_reset();
    step_to(1);  chk("s4_pend1", 32'(pedPending), 1);
    step_to(20); chk_phase("s4_c20", 2);
    step_to(24); chk("s4_pend24", 32'(pedPending), 0);
    step_to(28); chk_phase("s4_c28", 4);
    step_to(29); chk("s4_pend29", 32'(pedPending), 1);
    step_to(48); chk_phase("s4_c48", 6);
    step_to(50); chk("s4_pend50", 32'(pedPending), 0);
    step_to(56); chk_phase("s4_c56", 0);
    step_to(76); chk_phase("s4_c76", 2);
    pedReq = 1'b0;

    // Scenario 5: run=0 for 10 cycles mid EW_GREEN stretches it to 22 cycles.
    do_reset();
    step_to(24); chk("s5_tl24", 32'(timeLeft), 1); run = 1'b0;
    step_to(30); chk_phase("s5_c30", 4); chk("s5_tl30", 32'(timeLeft), 1);
    step_to(34); chk("s5_tl34", 32'(timeLeft), 1); run = 1'b1;
    step_to(38); chk("s5_tl38", 32'(timeLeft), 0);
    step_to(41); chk_phase("s5_c41", 4);
    step_to(42); chk_phase("s5_c42", 5); chk("s5_tl42", 32'(timeLeft), 1);

    // Scenario 6: asynchronous reset during EW_YELLOW with all latches set.
    do_reset();
    step_to(36); pedReq = 1'b1; nsLeftReq = 1'b1; ewLeftReq = 1'b1;
    step_to(37); pedReq = 1'b0; nsLeftReq = 1'b0; ewLeftReq = 1'b0;
    chk_phase("s6_c37", 5);
    chk("s6_ped37", 32'(pedPending), 1);
    chk("s6_nsl37", 32'(nsLeftPending), 1);
    chk("s6_ewl37", 32'(ewLeftPending), 1);
    step_to(38);
    #1 resetn = 1'b0;
    #1;
    chk_phase("s6_rst_fsm", 0);
    chk("s6_rst_tl", 32'(timeLeft), 2);
    chk("s6_rst_ped", 32'(pedPending), 0);
    chk("s6_rst_nsl", 32'(nsLeftPending), 0);
    chk("s6_rst_ewl", 32'(ewLeftPending), 0);
    @(negedge clock);
    resetn = 1'b1;
    cyc = 0;
    step_to(11); chk_phase("s6_c11", 0); chk("s6_tl11", 32'(timeLeft), 0);
    step_to(12); chk_phase("s6_c12", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
